// File: rtl/cfg_sel_out_pea_loader.sv
// rtl/cfg_sel_out_pea_loader.sv - PEA output-selector config loader with atomic idle-gated commit
module cfg_sel_out_pea_loader #(
  parameter  int N_OUT_PEA     = 8,
  parameter  int LOG_M         = 3,
  parameter  int CFG_BANK_SIZE = 2,
  localparam int TOT_BITS      = CFG_BANK_SIZE * N_OUT_PEA * LOG_M,
  localparam int N_WORDS       = (TOT_BITS + 31) / 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  input  logic [31:0]            word_data_i,
  input  logic                   pea_idle_i,
  output logic [N_WORDS*32-1:0]  reg_cfg_sel_out_pea_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_valid_o
);

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      shadow [N_WORDS];

  // Keeps padding above TOT_BITS at zero so the active vector never carries junk.
  function automatic logic [31:0] word_mask(input int k);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = ((k * 32 + i) < TOT_BITS);
    end
    return m;
  endfunction

  assign word_ready_o = (state == LOAD) && !abort_i;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                 <= IDLE;
      cnt                   <= '0;
      reg_cfg_sel_out_pea_o <= '0;
      done_o                <= 1'b0;
      cfg_valid_o           <= 1'b0;
      for (int w = 0; w < N_WORDS; w++) begin
        shadow[w] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (word_valid_i) begin
            shadow[cnt] <= word_data_i & word_mask(int'(cnt));
            if (cnt == LAST_CNT) begin
              state <= COMMIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          // Abort wins over a commit that would happen on the same edge.
          if (abort_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (pea_idle_i) begin
            for (int w = 0; w < N_WORDS; w++) begin
              reg_cfg_sel_out_pea_o[w*32 +: 32] <= shadow[w];
            end
            done_o      <= 1'b1;
            cfg_valid_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_sel_out_pea_loader.sv
// tb/tb_cfg_sel_out_pea_loader.sv - randomized self-checking bench for cfg_sel_out_pea_loader
module tb_cfg_sel_out_pea_loader;

  localparam int TOT = 48;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] word_data_i;
  logic        pea_idle_i;
  logic [63:0] reg_cfg_sel_out_pea_o;
  logic        busy_o;
  logic        done_o;
  logic        cfg_valid_o;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [63:0] exp_out = 64'h0;

  cfg_sel_out_pea_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
    .pea_idle_i(pea_idle_i), .reg_cfg_sel_out_pea_o(reg_cfg_sel_out_pea_o),
    .busy_o(busy_o), .done_o(done_o), .cfg_valid_o(cfg_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (!rst_i && word_valid_i && word_ready_o) hs_cnt++;
  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  // Word k lands at bits [32k+31:32k]; only the low TOT bits survive.
  function automatic logic [63:0] model_vec(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] v;
    logic [63:0] keep;
    v    = {32'h0, w0} + ({32'h0, w1} * 64'h1_0000_0000);
    keep = (64'd1 << TOT) - 64'd1;
    return v & keep;
  endfunction

  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                            input bit gaps, input bit restart);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    word_valid_i = 1'b1;
    word_data_i  = w0;
    @(negedge clk_i);
    if (gaps) begin
      word_valid_i = 1'b0;
      word_data_i  = $urandom;
      start_i      = restart;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    word_valid_i = 1'b1;
    word_data_i  = w1;
    @(negedge clk_i);
    word_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; word_valid_i = 1'b0;
    word_data_i = 32'h0; pea_idle_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    total++; if (reg_cfg_sel_out_pea_o !== 64'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", reg_cfg_sel_out_pea_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (cfg_valid_o !== 1'b0) begin bad++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid_o); end
    total++; if (word_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", word_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    pea_idle_i = 1'b1;
    load_words(32'hDEADBEEF, 32'hFFFF1234, 1'b0, 1'b0);
    exp_out = model_vec(32'hDEADBEEF, 32'hFFFF1234);
    total++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL basic_precommit done=%b busy=%b exp done=0 busy=1", done_o, busy_o); end
    @(negedge clk_i);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done_o); end
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || exp_out !== 64'h00001234_DEADBEEF) begin bad++; $display("FAIL basic_out got=%h exp=%h", reg_cfg_sel_out_pea_o, exp_out); end
    total++; if (cfg_valid_o !== 1'b1) begin bad++; $display("FAIL basic_cfg_valid got=%b exp=1", cfg_valid_o); end
    @(negedge clk_i);
    total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL basic_after done=%b busy=%b exp 0 0", done_o, busy_o); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_commit_hold;
    logic [63:0] prev;
    prev = exp_out;
    pea_idle_i = 1'b0;
    load_words(32'h11111111, 32'h00002222, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk_i);
      total++; if (reg_cfg_sel_out_pea_o !== prev || busy_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("FAIL hold_wait out=%h busy=%b done=%b exp out=%h busy=1 done=0", reg_cfg_sel_out_pea_o, busy_o, done_o, prev); end
    end
    pea_idle_i = 1'b1;
    exp_out = model_vec(32'h11111111, 32'h00002222);
    @(negedge clk_i);
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || done_o !== 1'b1) begin bad++; $display("FAIL hold_commit out=%h done=%b exp out=%h done=1", reg_cfg_sel_out_pea_o, done_o, exp_out); end
    @(negedge clk_i);
  endtask

  task automatic test_abort;
    int h0;
    int d0;
    logic [31:0] a;
    logic [31:0] b;
    h0 = hs_cnt; d0 = done_cnt;
    pea_idle_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    word_valid_i = 1'b1; word_data_i = $urandom;
    @(negedge clk_i);
    word_data_i = $urandom; abort_i = 1'b1;
    #1;
    total++; if (word_ready_o !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", word_ready_o); end
    @(negedge clk_i);
    abort_i = 1'b0; word_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b0 || hs_cnt - h0 !== 1) begin bad++; $display("FAIL abort_state busy=%b hs=%0d exp busy=0 hs=1", busy_o, hs_cnt - h0); end
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || done_cnt !== d0) begin bad++; $display("FAIL abort_out out=%h pulses=%0d exp out=%h pulses=0", reg_cfg_sel_out_pea_o, done_cnt - d0, exp_out); end
    // abort arriving together with a commit opportunity
    pea_idle_i = 1'b0;
    load_words($urandom, $urandom, 1'b0, 1'b0);
    abort_i = 1'b1; pea_idle_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    @(negedge clk_i);
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || done_cnt !== d0 || busy_o !== 1'b0) begin bad++; $display("FAIL abort_commit out=%h pulses=%0d busy=%b exp out=%h pulses=0 busy=0", reg_cfg_sel_out_pea_o, done_cnt - d0, busy_o, exp_out); end
    // start and abort together in IDLE: start wins
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL start_vs_abort busy=%b exp=1", busy_o); end
    @(negedge clk_i);
    abort_i = 1'b0;
    a = $urandom; b = $urandom;
    load_words(a, b, 1'b0, 1'b0);
    exp_out = model_vec(a, b);
    @(negedge clk_i);
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || done_o !== 1'b1) begin bad++; $display("FAIL abort_reload out=%h done=%b exp out=%h done=1", reg_cfg_sel_out_pea_o, done_o, exp_out); end
    @(negedge clk_i);
  endtask

  task automatic test_gaps_restart;
    int h0;
    int d0;
    logic [31:0] a;
    logic [31:0] b;
    h0 = hs_cnt; d0 = done_cnt;
    a = $urandom; b = $urandom;
    pea_idle_i = 1'b1;
    load_words(a, b, 1'b1, 1'b1);
    exp_out = model_vec(a, b);
    repeat (4) @(negedge clk_i);
    total++; if (hs_cnt - h0 !== 2 || done_cnt - d0 !== 1) begin bad++; $display("FAIL gaps_counts hs=%0d pulses=%0d exp hs=2 pulses=1", hs_cnt - h0, done_cnt - d0); end
    total++; if (reg_cfg_sel_out_pea_o !== exp_out || busy_o !== 1'b0) begin bad++; $display("FAIL gaps_out out=%h busy=%b exp out=%h busy=0", reg_cfg_sel_out_pea_o, busy_o, exp_out); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] prev;
      int hold;
      a = $urandom; b = $urandom;
      hold = $urandom_range(0, 3);
      prev = exp_out;
      pea_idle_i = (hold == 0);
      load_words(a, b, bit'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk_i);
        total++; if (reg_cfg_sel_out_pea_o !== prev) begin bad++; $display("FAIL rand_hold it=%0d got=%h exp=%h", it, reg_cfg_sel_out_pea_o, prev); end
      end
      pea_idle_i = 1'b1;
      exp_out = model_vec(a, b);
      for (int k = 0; k < 5 && done_o !== 1'b1; k++) @(negedge clk_i);
      total++; if (done_o !== 1'b1 || reg_cfg_sel_out_pea_o !== exp_out) begin bad++; $display("FAIL rand_commit it=%0d done=%b got=%h exp=%h", it, done_o, reg_cfg_sel_out_pea_o, exp_out); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_in_commit;
    pea_idle_i = 1'b0;
    load_words($urandom, $urandom, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    total++; if (reg_cfg_sel_out_pea_o !== 64'h0 || cfg_valid_o !== 1'b0) begin bad++; $display("FAIL rst_commit_out out=%h cfg_valid=%b exp 0 0", reg_cfg_sel_out_pea_o, cfg_valid_o); end
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL rst_commit_state busy=%b done=%b exp 0 0", busy_o, done_o); end
    rst_i = 1'b0; pea_idle_i = 1'b1;
    exp_out = 64'h0;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_commit_hold;
    test_abort;
    test_gaps_restart;
    test_random;
    test_reset_in_commit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
